// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle memory access unit between the main control
// FSM and the unified instruction/data memory. Converts single-cycle
// MemRead/MemWrite/IRWrite/IorD strobes into a req/ack bus transaction and
// holds the instruction register (IR) and memory data register (MDR).
// Optional feature macro: MEM_TIMEOUT_EN (aborts a REQ that sees no ack
// within TIMEOUT cycles and raises a sticky bus_err).
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; latches the transaction on a strobe
// REQ   | bus_req high, transaction held stable until bus_ack (or timeout)
// DONE  | one cycle with stall low so the controller advances; strobes ignored
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic              iord,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [6:0]        opcode,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              dest_ir;
  logic              start;
  logic              ack_req;
  logic              abort;
  logic [ADDR_W-1:0] addr_sel;

  assign start    = (state == IDLE) && (mem_read || mem_write);
  assign ack_req  = (state == REQ) && bus_ack;
  assign addr_sel = iord ? alu_out : pc;

  // bus_req comes straight from the state register, so it is glitch-free and
  // drops as soon as the async reset forces IDLE.
  assign bus_req = (state == REQ);
  assign stall   = start || (state == REQ);
  assign opcode  = ir[6:0];

`ifdef MEM_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] req_cnt;
  logic             err_q;

  // Counts completed REQ cycles; the abort fires in the TIMEOUT-th REQ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            req_cnt <= '0;
    else if (start)                     req_cnt <= '0;
    else if (state == REQ && !bus_ack)  req_cnt <= req_cnt + 1'b1;
  end

  // An ack in the final REQ cycle takes priority over the timeout.
  assign abort = (state == REQ) && !bus_ack && (req_cnt == CNT_LAST);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        err_q <= 1'b0;
    else if (abort) err_q <= 1'b1;
  end

  assign bus_err = err_q;
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (ack_req || abort) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the transaction on the IDLE strobe; held untouched through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      dest_ir   <= 1'b0;
    end else if (start) begin
      bus_we    <= mem_write;
      bus_addr  <= {addr_sel[ADDR_W-1:2], 2'b00};
      bus_wdata <= wdata;
      dest_ir   <= ir_write && !mem_write;
    end
  end

  // Capture read data into IR or MDR on an acked read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir  <= '0;
      mdr <= '0;
    end else if (ack_req && !bus_we) begin
      if (dest_ir) ir  <= bus_rdata;
      else         mdr <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Expected IR/MDR contents are
// computed when each access is launched, queued, and compared in DONE.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        iord;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [31:0] wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [31:0] mdr;
  logic        stall;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ir;
  logic [31:0] m_mdr;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .iord      (iord),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .ir        (ir),
    .opcode    (opcode),
    .mdr       (mdr),
    .stall     (stall),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One controller access. Called just after a posedge with the DUT in IDLE.
  // ack_k is the cycle (strobe cycle = 0) in which bus_ack is driven.
  task automatic run_access(input logic rd, input logic wr, input logic irw,
                            input logic sel, input logic [31:0] pc_i,
                            input logic [31:0] alu_i, input logic [31:0] wd,
                            input int ack_k, input logic [31:0] rdat,
                            input logic scramble);
    logic [31:0] exp_addr;
    exp_t        e;
    exp_addr = (sel ? alu_i : pc_i) & 32'hFFFF_FFFC;
    mem_read = rd; mem_write = wr; ir_write = irw; iord = sel;
    pc = pc_i; alu_out = alu_i; wdata = wd;
    if (rd && !wr) begin
      if (irw) m_ir = rdat;
      else     m_mdr = rdat;
    end
    sb.push_back('{ir: m_ir, mdr: m_mdr});
    for (int c = 0; c <= ack_k; c++) begin
      if (c == ack_k) begin
        bus_ack = 1'b1;
        bus_rdata = rdat;
      end
      if (c == 1 && scramble) begin
        wdata = ~wd; pc = ~pc_i; alu_out = ~alu_i; iord = ~sel; ir_write = ~irw;
      end
      @(negedge clk);
      chk("stall_busy", {31'd0, stall}, 32'd1);
      if (c >= 1) begin
        chk("bus_req", {31'd0, bus_req}, 32'd1);
        chk("bus_we", {31'd0, bus_we}, {31'd0, wr});
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_wdata", bus_wdata, wd);
      end
      step();
    end
    bus_ack = 1'b0;
    bus_rdata = 32'h5A5A_5A5A;
    // DONE: strobes still high, controller released.
    @(negedge clk);
    chk("stall_done", {31'd0, stall}, 32'd0);
    chk("req_done", {31'd0, bus_req}, 32'd0);
    chk("sb_size", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ir", ir, e.ir);
      chk("opcode", {25'd0, opcode}, {25'd0, e.ir[6:0]});
      chk("mdr", mdr, e.mdr);
    end
    step();
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
    @(negedge clk);
    chk("req_after", {31'd0, bus_req}, 32'd0);
    chk("stall_idle", {31'd0, stall}, 32'd0);
    step();
    chk("no_second_req", {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic rd_r, wr_r, irw_r, sel_r;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; iord = 1'b0;
    pc = '0; alu_out = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    m_ir = '0; m_mdr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b0;
    step();

    // Reset in the middle of a REQ.
    mem_read = 1'b1; iord = 1'b1; alu_out = 32'h0000_0777; wdata = 32'h1111_2222; mem_write = 1'b1;
    step();
    chk("req_before_rst", {31'd0, bus_req}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("req_async_rst", {31'd0, bus_req}, 32'd0);
    chk("we_async_rst", {31'd0, bus_we}, 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_req", {31'd0, bus_req}, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_addr", bus_addr, 32'd0);
    chk("post_rst_wdata", bus_wdata, 32'd0);
    step();
    chk("post_rst_idle", {31'd0, bus_req}, 32'd0);

    // Instruction fetch, load, store with changing inputs, read+write collision.
    run_access(1, 0, 1, 0, 32'h0000_0104, 32'h0, 32'h0, 3, 32'h00A3_0233, 0);
    run_access(1, 0, 0, 1, 32'h0, 32'h0000_0203, 32'h0, 1, 32'hDEAD_BEEF, 0);
    run_access(0, 1, 0, 1, 32'h0, 32'h0000_0040, 32'h1234_5678, 4, 32'hFFFF_0000, 1);
    run_access(1, 1, 1, 0, 32'h0000_0502, 32'h0, 32'hCAFE_F00D, 2, 32'h1111_1111, 0);
    run_access(1, 0, 0, 1, 32'h0, 32'h0000_1000, 32'h0, 6, 32'h0BAD_CAFE, 1);

    // ir_write without mem_read does nothing.
    ir_write = 1'b1;
    @(negedge clk);
    chk("irw_only_stall", {31'd0, stall}, 32'd0);
    step();
    chk("irw_only_req", {31'd0, bus_req}, 32'd0);
    ir_write = 1'b0;

    // Ack pulsed in IDLE is ignored.
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    step();
    bus_ack = 1'b0;
    chk("idle_ack_ir", ir, m_ir);
    chk("idle_ack_mdr", mdr, m_mdr);
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);

    // A few random accesses.
    for (int i = 0; i < 6; i++) begin
      rd_r = 1'($urandom_range(0, 1));
      wr_r = ~rd_r | 1'($urandom_range(0, 1));
      irw_r = 1'($urandom_range(0, 1));
      sel_r = 1'($urandom_range(0, 1));
      run_access(rd_r, wr_r, irw_r, sel_r, $urandom, $urandom, $urandom,
                 $urandom_range(1, 8), $urandom, 1'($urandom_range(0, 1)));
    end

`ifdef MEM_TIMEOUT_EN
    // Ack in the last allowed REQ cycle wins over the timeout.
    run_access(1, 0, 0, 1, 32'h0, 32'h0000_0600, 32'h0, 15, 32'h7777_8888, 0);
    chk("err_ack_wins", {31'd0, bus_err}, 32'd0);

    // No ack: abort after TIMEOUT REQ cycles.
    mem_read = 1'b1; iord = 1'b1; alu_out = 32'h0000_0300;
    step();
    n = 0;
    while (bus_req && n < 40) begin
      n++;
      step();
    end
    chk("timeout_cycles", n, 32'd15);
    chk("timeout_err", {31'd0, bus_err}, 32'd1);
    chk("timeout_stall", {31'd0, stall}, 32'd0);
    chk("timeout_mdr", mdr, m_mdr);
    chk("timeout_ir", ir, m_ir);
    step();
    mem_read = 1'b0;
    step();
    run_access(1, 0, 0, 1, 32'h0, 32'h0000_0304, 32'h0, 2, 32'h4242_4242, 0);
    chk("err_sticky", {31'd0, bus_err}, 32'd1);
`else
    chk("err_tied", {31'd0, bus_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle memory access unit between the main control FSM and the unified instruction/data memory. Turns the controller's single-cycle MemRead/MemWrite/IRWrite/IorD strobes into a req/ack bus transaction of variable latency. Holds the instruction register (IR) and memory data register (MDR). Asserts `stall` so the controller holds its state until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus data, IR and MDR width
- `TIMEOUT`, 15, maximum REQ cycles without ack before abort (timeout build only; must be ≥1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `mem_read`  in  1  controller read strobe
- `mem_write`  in  1  controller write strobe
- `ir_write`  in  1  read data goes to IR instead of MDR
- `iord`  in  1  address select: 0 = `pc`, 1 = `alu_out`
- `pc`  in  ADDR_W  program counter
- `alu_out`  in  ADDR_W  ALUOut register (data address)
- `wdata`  in  DATA_W  store data (B register)
- `bus_req`  out  1  transaction request
- `bus_we`  out  1  1 = write
- `bus_addr`  out  ADDR_W  word-aligned address
- `bus_wdata`  out  DATA_W  write data
- `bus_ack`  in  1  memory completion
- `bus_rdata`  in  DATA_W  read data, valid with `bus_ack`
- `ir`  out  DATA_W  instruction register
- `opcode`  out  7  `ir[6:0]`
- `mdr`  out  DATA_W  memory data register
- `stall`  out  1  controller must hold its state
- `bus_err`  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - If `mem_read | mem_write`, latch the following and go to REQ:
    - `bus_we = mem_write` (write wins if both are high)
    - `bus_addr = (iord ? alu_out : pc)` with `[1:0]` forced to 00
    - `bus_wdata = wdata`
    - an internal destination flag = `ir_write & ~mem_write`
  - Otherwise stay in IDLE.
- **REQ**
  - `bus_req` = 1.
  - `bus_we`, `bus_addr` and `bus_wdata` are held stable until ack.
  - On `bus_ack`:
    - Read with destination flag set: `ir <= bus_rdata`.
    - Read with flag clear: `mdr <= bus_rdata`.
    - Write: `ir` and `mdr` unchanged.
    - Go to DONE.
- **DONE**
  - One cycle. `bus_req` = 0 and `stall` = 0, so the controller advances at this edge.
  - Requests are ignored in DONE, because the controller's strobes are still high. Always go to IDLE.
- `stall` is combinational: `(IDLE & (mem_read | mem_write)) | REQ`.
- `bus_ack` is ignored in IDLE and DONE.
- `ir_write` with no `mem_read` is ignored.
- Input changes during REQ have no effect on the latched transaction.

## Timing
- Reset values: state IDLE, all of the following 0: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `ir`, `mdr`, `bus_err`.
- `rst` asserted mid-transaction: `bus_req` drops immediately and the transaction is abandoned.
- `bus_req` is registered. It rises the cycle after the strobe is seen in IDLE.
- Cycle numbering, with cycle 0 = strobe seen in IDLE:
  - Ack in cycle 1 (minimum latency): `ir`/`mdr` update at the end of cycle 1, DONE in cycle 2.
  - General case: ack in cycle k gives DONE in cycle k+1, so stall lasts k+1 cycles.
- Back-to-back accesses: the earliest next request is accepted in the IDLE cycle after DONE.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A REQ-cycle counter (clog2(TIMEOUT+1) bits) clears on entry to REQ.
  - If the counter reaches TIMEOUT with no ack: `bus_req` drops, `bus_err` is set (sticky until `rst`), FSM goes to DONE, and `ir`/`mdr` stay unchanged.
  - Ack in the same cycle the counter reaches TIMEOUT: ack wins and there is no error.
- `MEM_TIMEOUT_EN` undefined:
  - REQ waits indefinitely.
  - `bus_err` is tied to 0 and there is no counter.

## Test plan
- **Reset:** assert `rst` during REQ → `bus_req` = 0 immediately; after release all outputs are 0 and the state is IDLE.
- **Instruction fetch:** `mem_read=1 ir_write=1 iord=0 pc=0x104`, ack in cycle 3 with `rdata=0x00A30233` → `bus_addr=0x104`, `bus_we=0`, `ir=0x00A30233`, `opcode=0x33`, `mdr` unchanged, `stall` high for cycles 0–3 and low in cycle 4.
- **Load:** `mem_read=1 iord=1 alu_out=0x203`, ack in cycle 1 with `rdata=0xDEADBEEF` → `bus_addr=0x200`, `mdr=0xDEADBEEF`, `ir` unchanged, DONE in cycle 2.
- **Store:** `mem_write=1 iord=1 alu_out=0x40 wdata=0x12345678`; `wdata` changes during REQ → `bus_we=1` and `bus_wdata` stays `0x12345678` until ack; `ir` and `mdr` unchanged.
- **Timeout** (`MEM_TIMEOUT_EN`, TIMEOUT=15): read with no ack → after 15 REQ cycles `bus_req` = 0, `bus_err` = 1, DONE; a following acked read still sets `mdr` and `bus_err` stays 1.
- **Edge cases:** `mem_read` and `mem_write` both high → write issued; ack pulsed in IDLE → ignored; strobes held high through DONE → no second transaction.
